// File: rtl/rr_data_arbiter.sv
// Round-robin arbiter sharing one data channel between NUM_REQ producers.
// Grants are registered and held for up to MAX_BURST accepted beats; data passes through combinationally.
module rr_data_arbiter #(
    parameter int WIDTH     = 32,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4,
    localparam int ID_W     = $clog2(NUM_REQ),
    localparam int CNT_W    = $clog2(MAX_BURST + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] in_data,
    output logic [NUM_REQ-1:0]       in_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     out_ready,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [ID_W-1:0]          gnt_id,
    output logic                     busy,
    output logic [CNT_W-1:0]         beat_cnt
);

    // Handshake: a beat moves when out_valid && out_ready; in_ready mirrors that onto the granted bit.
    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [ID_W-1:0]    gnt_id_q;
    logic [ID_W-1:0]    ptr_q;
    logic [CNT_W-1:0]   beat_cnt_q;

    logic               cur_req;
    logic               xfer;
    logic               last_beat;
    logic               rel;
    logic [ID_W-1:0]    next_ptr;
    logic [ID_W-1:0]    search_ptr;
    logic [ID_W-1:0]    idx;
    logic [ID_W-1:0]    found_id;
    logic               found;

    assign busy      = (state_q == BUSY);
    assign cur_req   = req[gnt_id_q];
    assign xfer      = busy && cur_req && out_ready;
    assign last_beat = (beat_cnt_q == CNT_W'(MAX_BURST - 1));
    assign rel       = busy && (!cur_req || (xfer && last_beat));
    assign next_ptr  = ID_W'((int'(gnt_id_q) + 1) % NUM_REQ);

    // On release the old owner drops to lowest priority, so the search starts just past it.
    assign search_ptr = busy ? next_ptr : ptr_q;

    always_comb begin
        found    = 1'b0;
        found_id = '0;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(search_ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found    = 1'b1;
                found_id = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            ptr_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        state_q    <= BUSY;
                        gnt_q      <= NUM_REQ'(1) << found_id;
                        gnt_id_q   <= found_id;
                        beat_cnt_q <= '0;
                    end
                end
                BUSY: begin
                    if (rel) begin
                        ptr_q      <= next_ptr;
                        beat_cnt_q <= '0;
                        if (found) begin
                            gnt_q    <= NUM_REQ'(1) << found_id;
                            gnt_id_q <= found_id;
                        end else begin
                            state_q  <= IDLE;
                            gnt_q    <= '0;
                            gnt_id_q <= '0;
                        end
                    end else if (xfer) begin
                        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign beat_cnt  = beat_cnt_q;
    assign out_valid = busy && cur_req;
    assign out_data  = out_valid ? in_data[int'(gnt_id_q)*WIDTH +: WIDTH] : '0;
    assign in_ready  = (busy && out_ready) ? gnt_q : '0;

endmodule

// File: tb/tb_rr_data_arbiter.sv
// Randomized scoreboard bench for rr_data_arbiter with a per-owner burst model.
module tb_rr_data_arbiter;

  localparam int W   = 8;
  localparam int N   = 4;
  localparam int MB  = 4;
  localparam int IDW = 2;
  localparam int CW  = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;
  logic [CW-1:0]  beat_cnt;

  rr_data_arbiter #(.WIDTH(W), .NUM_REQ(N), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .beat_cnt(beat_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [IDW+W-1:0] exp_q[$];

  // reference model: who owns the channel, how many beats it has moved, where the search starts
  int   m_owner = -1;
  int   m_beats = 0;
  int   m_ptr   = 0;
  bit   m_known = 1'b0;
  logic [W-1:0] dat [N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int from);
    for (int k = 0; k < N; k++) begin
      if (r[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  task automatic drive_cycle(input logic [N-1:0] r, input logic ordy, input logic rs);
    logic [N-1:0] e_gnt;
    logic         e_valid;
    @(negedge clk);
    req       = r;
    out_ready = ordy;
    rst       = rs;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = dat[i];
    #1;
    if (m_known) begin
      e_gnt   = (m_owner >= 0) ? N'(1) << m_owner : '0;
      e_valid = (m_owner >= 0) && r[m_owner];
      check("busy", 32'(busy), 32'(m_owner >= 0));
      check("gnt", 32'(gnt), 32'(e_gnt));
      check("gnt_id", 32'(gnt_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
      check("beat_cnt", 32'(beat_cnt), 32'(m_beats));
      check("out_valid", 32'(out_valid), 32'(e_valid));
      check("out_data", 32'(out_data), e_valid ? 32'(dat[m_owner]) : 32'd0);
      check("in_ready", 32'(in_ready), ((m_owner >= 0) && ordy) ? 32'(e_gnt) : 32'd0);
      if (e_valid && ordy) exp_q.push_back({IDW'(m_owner), dat[m_owner]});
    end
    @(posedge clk);
    if (rs) begin
      m_owner = -1; m_beats = 0; m_ptr = 0; m_known = 1'b1;
    end else if (m_known) begin
      if (m_owner < 0) begin
        m_owner = pick(r, m_ptr);
        m_beats = 0;
      end else begin
        bit done;
        done = !r[m_owner];
        if (!done && ordy) begin
          m_beats++;
          done = (m_beats == MB);
        end
        if (done) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = pick(r, m_ptr);
          m_beats = 0;
        end
      end
    end
  endtask

  // monitor: pops an expected beat whenever the DUT presents an accepted transfer
  initial begin
    logic [IDW+W-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat unexpected actual=%0h expected=none", {gnt_id, out_data});
        end else begin
          e = exp_q.pop_front();
          check("beat", 32'({gnt_id, out_data}), 32'(e));
        end
      end
    end
  end

  initial begin
    logic [N-1:0] rs_bits;
    rst = 1'b1; req = '0; out_ready = 1'b0; in_data = '0;
    for (int i = 0; i < N; i++) dat[i] = W'(8'h10 + i);

    // reset and idle
    drive_cycle(4'b0000, 1'b0, 1'b1);
    drive_cycle(4'b0000, 1'b0, 1'b1);
    repeat (5) drive_cycle(4'b0000, 1'b1, 1'b0);

    // single requester, re-granted with no gap
    dat[2] = 8'hA5;
    repeat (12) drive_cycle(4'b0100, 1'b1, 1'b0);

    // full rotation
    drive_cycle(4'b0000, 1'b1, 1'b1);
    repeat (22) drive_cycle(4'b1111, 1'b1, 1'b0);

    // backpressure on requester 1, then release
    drive_cycle(4'b0000, 1'b1, 1'b1);
    repeat (11) drive_cycle(4'b0010, 1'b0, 1'b0);
    repeat (8) drive_cycle(4'b0110, 1'b1, 1'b0);

    // withdrawal after two beats
    drive_cycle(4'b0000, 1'b1, 1'b1);
    repeat (3) drive_cycle(4'b0011, 1'b1, 1'b0);
    repeat (6) drive_cycle(4'b0010, 1'b1, 1'b0);

    // reset during beat 2, then lowest requesting index wins
    drive_cycle(4'b0000, 1'b1, 1'b1);
    repeat (2) drive_cycle(4'b0000, 1'b1, 1'b0);
    repeat (3) drive_cycle(4'b1111, 1'b1, 1'b0);
    drive_cycle(4'b1111, 1'b1, 1'b1);
    repeat (4) drive_cycle(4'b1010, 1'b1, 1'b0);

    // random sticky requests with random backpressure and data
    rs_bits = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) rs_bits[i] = ~rs_bits[i];
        dat[i] = W'($urandom);
      end
      drive_cycle(rs_bits, ($urandom_range(0, 3) != 0), ($urandom_range(0, 299) == 0));
    end

    repeat (2) drive_cycle(4'b0000, 1'b0, 1'b0);
    check("exp_q drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_data_arbiter.md
Name: rr_data_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit data channel between NUM_REQ requesters and a single consumer.
- Grants one requester at a time and holds the grant for a burst of up to MAX_BURST accepted beats. It then rotates priority.
- Sits between several data producers and one consumer module reading the channel.
- Arbitration is registered; once granted, data passes combinationally from the granted requester to the output.

Parameters:
- WIDTH, 32, data bits per beat; must be >= 1.
- NUM_REQ, 4, number of requesters; must be >= 2.
- MAX_BURST, 4, maximum accepted beats per grant; must be >= 1.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester valid; bit i belongs to requester i.
- in_data  input  NUM_REQ*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  NUM_REQ  beat from requester i accepted this cycle (gnt[i] && out_ready && busy).
- out_valid  output  1  req[gnt_id] while busy, else 0.
- out_data  output  WIDTH  in_data slice of gnt_id while out_valid, else 0.
- out_ready  input  1  consumer accepts the beat.
- gnt  output  NUM_REQ  one-hot registered grant; all zero when idle.
- gnt_id  output  $clog2(NUM_REQ)  index of the granted requester; 0 when idle.
- busy  output  1  state == BUSY.
- beat_cnt  output  $clog2(MAX_BURST+1)  beats accepted in the current grant.

Behaviour:
- Reset values: gnt = 0, gnt_id = 0, busy = 0, beat_cnt = 0, out_valid = 0, out_data = 0, in_ready = 0.
- Reset also sets the internal rotation pointer ptr = 0. Reset mid-burst clears everything at the next edge and counts no beat.
- Transfer (xfer): busy && req[gnt_id] && out_ready. It occurs in the same cycle as in_ready[gnt_id].
- Priority search: the first index with req set, scanning from ptr up through NUM_REQ-1 and then wrapping from 0 to ptr-1.

State machine, IDLE:
- If any req bit is set, load gnt/gnt_id from the priority search on that cycle's req, set beat_cnt = 0 and go to BUSY.
- Grant is visible the cycle after the request: 1-cycle arbitration latency.
- If no req bit is set, stay in IDLE.

State machine, BUSY:
- Each xfer increments beat_cnt.
- The grant is released when either of these holds:
  - req[gnt_id] == 0 (requester withdrew; no beat counted that cycle), or
  - xfer occurs with beat_cnt == MAX_BURST-1 (burst exhausted).
- On release, ptr <= (gnt_id+1) mod NUM_REQ. The next grant is chosen in the same cycle by a priority search over the current req starting at that new ptr.
  - If a requester is found, stay in BUSY with the new grant and beat_cnt = 0; there are no idle bubbles between grants.
  - The previous owner is lowest priority, so it regains the grant only if it is the sole requester.
  - If no requester is found, go to IDLE with gnt = 0.
- No release while req[gnt_id] == 1 and out_ready == 0: the grant holds indefinitely under backpressure.

Fairness and data rules:
- Requests from non-granted requesters never affect the current grant.
- Requesters must not see in_ready while not granted.
- Once granted, a requester holding req high is guaranteed to reach MAX_BURST accepted beats before losing the grant.
- Data is not registered. out_data must be zero-forced whenever out_valid == 0; no stale data appears.
- gnt is always one-hot or zero, and gnt_id is always consistent with gnt.
- beat_cnt never exceeds MAX_BURST-1 while visible; it wraps to 0 on a new grant.

Test Plan:
- Reset, idle: rst high 2 cycles, req = 0 -> all outputs 0. After release with req = 0 for 5 cycles -> still IDLE, gnt = 0.
- Single requester burst: NUM_REQ = 4, MAX_BURST = 4, req = 4'b0100 constant, out_ready = 1, in_data[2] = 8'hA5 (WIDTH = 8).
  - Cycle after request: gnt = 0100, gnt_id = 2, out_data = A5.
  - After 4 xfers, requester 2 is re-granted with no gap (sole requester); beat_cnt goes 0,1,2,3,0.
- Round-robin rotation: req = 4'b1111 constant, out_ready = 1 -> gnt_id sequence 0,1,2,3,0, each held exactly 4 cycles. in_ready is asserted only on the granted bit.
- Backpressure: requester 1 granted, out_ready = 0 for 10 cycles -> gnt holds, beat_cnt stays 0, in_ready = 0.
  - out_ready then goes high -> 4 beats, then the grant moves to the next requester.
- Withdrawal and reset:
  - req = 4'b0011, requester 0 drops req after 2 beats -> the same cycle sees out_valid = 0; the next edge grants 1 with beat_cnt = 0.
  - Separately, asserting rst during beat 2 of a burst -> next cycle gnt = 0, busy = 0, ptr = 0. The first grant after reset goes to the lowest requesting index.
